// File: rtl/fir_pkg.sv
// Shared types and sizing for the time-multiplexed FIR MAC sequencer.
// Imported by fir_coef_bank and fir_mac_sequencer.
package fir_pkg;

    localparam int DATA_W = 16;
    localparam int TAPS   = 4;
    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + ADDR_W;

    localparam logic [ACC_W-1:0] Y_MAX =
        {{(ACC_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: TAPS x DATA_W, synchronous write,
// combinational read, asynchronous active-low clear.
module fir_coef_bank
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_h [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_h[i] <= '0;
            end
        end else if (i_we) begin
            r_h[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_h[i_raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller: delay line, FSM and one shared MAC over TAPS cycles.
// Define FIR_OUT_SAT_EN to saturate y instead of wrapping modulo 2**DATA_W.
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    output logic              coef_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              busy
);

    fir_state_t        r_state;
    fir_state_t        w_state_nxt;

    logic [DATA_W-1:0] r_d [TAPS];
    logic [ACC_W-1:0]  r_acc;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_y;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_last;
    logic              w_pop;
    logic              w_coef_wr;
    logic [DATA_W-1:0] w_h;
    logic [DATA_W-1:0] w_dsel;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_res;

    fir_coef_bank u_coef_bank (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_coef_wr),
        .i_waddr (coef_addr),
        .i_wdata (coef_data),
        .i_raddr (r_idx),
        .o_rdata (w_h)
    );

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = r_out_valid & out_ready;
    assign w_coef_wr = coef_we & coef_ready;
    assign w_last    = (r_idx == ADDR_W'(TAPS - 1));

    assign w_dsel = r_d[r_idx];
    assign w_prod = PROD_W'(w_h) * PROD_W'(w_dsel);
    assign w_sum  = r_acc + ACC_W'(w_prod);

`ifdef FIR_OUT_SAT_EN
    assign w_res = (w_sum > Y_MAX) ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
    assign w_res = w_sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        coef_ready  = 1'b1;
        busy        = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = MAC;
                end
            end
            MAC: begin
                coef_ready = 1'b0;
                busy       = 1'b1;
                if (w_last) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                busy = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Delay line shifts only on accept, so d[] is frozen during the MAC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_d[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                r_d[k] <= r_d[k-1];
            end
            r_d[0] <= x;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_idx       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc <= '0;
                r_idx <= '0;
            end
            if (r_state == MAC) begin
                r_acc <= w_sum;
                r_idx <= r_idx + ADDR_W'(1);
                if (w_last) begin
                    r_y         <= w_res;
                    r_out_valid <= 1'b1;
                end
            end
            if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a transaction-level model
// checked every cycle, plus literal expectations for each scenario.
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              coef_we = 1'b0;
    logic [ADDR_W-1:0] coef_addr = '0;
    logic [DATA_W-1:0] coef_data = '0;
    logic              coef_ready;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] x = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] y;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    fir_mac_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one pending result that becomes visible TAPS
    // edges after its accept and retires on the first out_ready edge.
    logic [DATA_W-1:0] m_h [TAPS];
    logic [DATA_W-1:0] m_d [TAPS];
    bit                m_pend = 0;
    int                m_rdy = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] m_pend_y = '0;
    logic [DATA_W-1:0] m_last_y = '0;

    function automatic logic [DATA_W-1:0] model_y();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) begin
            s += longint'(m_h[k]) * longint'(m_d[k]);
        end
`ifdef FIR_OUT_SAT_EN
        if (s > 65535) s = 65535;
`endif
        return DATA_W'(s);
    endfunction

    initial begin
        for (int k = 0; k < TAPS; k++) begin
            m_h[k] = '0;
            m_d[k] = '0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend   = 0;
            m_last_y = '0;
            for (int k = 0; k < TAPS; k++) begin
                m_h[k] = '0;
                m_d[k] = '0;
            end
        end else begin
            cyc++;
            if (coef_we && !(m_pend && cyc <= m_rdy)) begin
                m_h[coef_addr] = coef_data;
            end
            if (m_pend && cyc > m_rdy && out_ready) begin
                m_pend   = 0;
                m_last_y = m_pend_y;
            end else if (!m_pend && in_valid) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    m_d[k] = m_d[k-1];
                end
                m_d[0]   = x;
                m_pend_y = model_y();
                m_pend   = 1;
                m_rdy    = cyc + TAPS;
            end
        end
    end

    always begin
        bit ov;
        @(posedge clk);
        #1;
        if (reset) begin
            ov = m_pend && (cyc >= m_rdy);
            chk("cmp_out_valid", out_valid, ov);
            chk("cmp_in_ready", in_ready, !m_pend);
            chk("cmp_coef_ready", coef_ready, !(m_pend && cyc < m_rdy));
            chk("cmp_busy", busy, m_pend);
            chk("cmp_y", y, ov ? m_pend_y : m_last_y);
        end
    end

    task automatic write_coef(input int a, input logic [DATA_W-1:0] v);
        bit ok = 0;
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = ADDR_W'(a);
        coef_data = v;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            ok = coef_ready;
        end
        chk("coef_wr_done", ok, 1);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] xv,
                        input logic [DATA_W-1:0] ey,
                        input int stall);
        bit ok = 0;
        int t0 = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        x         = xv;
        out_ready = (stall == 0);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            ok = in_ready;
            #1;
            t0 = cyc;
        end
        chk("accept_done", ok, 1);
        @(negedge clk);
        in_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = out_valid;
        end
        chk("out_valid_seen", ok, 1);
        chk("latency", cyc - t0, TAPS);
        chk("y_literal", y, ey);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_y", y, ey);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        if (stall != 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("popped", out_valid, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] big_y;
`ifdef FIR_OUT_SAT_EN
        big_y = 16'hFFFF;
`else
        big_y = 16'h0001;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", y, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_coef_ready", coef_ready, 1);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < TAPS; k++) begin
            write_coef(k, DATA_W'(k + 1));
        end
        send(16'd1, 16'd1, 5);
        send(16'd2, 16'd4, 0);
        send(16'd3, 16'd10, 0);
        send(16'd4, 16'd20, 0);

        write_coef(0, 16'hFFFF);
        for (int k = 1; k < TAPS; k++) begin
            write_coef(k, 16'd0);
        end
        send(16'hFFFF, big_y, 0);

        write_coef(0, 16'd1);
        fork
            send(16'd7, 16'd7, 0);
            begin
                repeat (3) @(negedge clk);
                chk("coef_blocked_in_mac", coef_ready, 0);
                write_coef(0, 16'd9);
            end
        join
        send(16'd8, 16'd72, 0);

        @(negedge clk);
        in_valid = 1'b1;
        x        = 16'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_y", y, 0);
        chk("post_rst_in_ready", in_ready, 1);
        send(16'd5, 16'd0, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
